// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 scancode decoder: make/break/extended tracking, typematic filter, ASCII map, press counter
module ps2_scancode_decoder (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] data,
   input  logic       ready,
   output logic [7:0] scancode,
   output logic [7:0] ascii,
   output logic       key_down,
   output logic       shift,
   output logic       key_valid,
   output logic [7:0] press_count
);

   typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;

   localparam logic [7:0] BYTE_BRK = 8'hF0;
   localparam logic [7:0] BYTE_EXT = 8'hE0;
   localparam logic [7:0] LSHIFT   = 8'h12;
   localparam logic [7:0] RSHIFT   = 8'h59;

   state_t     state_q, state_d;
   logic       shl_q, shl_d;
   logic       shr_q, shr_d;
   logic [7:0] code_q, code_d;
   logic [7:0] ascii_q, ascii_d;
   logic       down_q, down_d;
   logic       valid_q, valid_d;
   logic [7:0] count_q, count_d;

   // Letters are mapped to lowercase; Shift folds them to uppercase afterwards.
   function automatic logic [7:0] ascii_map(input logic [7:0] c, input logic sh);
      logic [7:0] lc;
      logic       letter;
      lc     = 8'h00;
      letter = 1'b1;
      case (c)
         8'h1C: lc = 8'h61;  8'h32: lc = 8'h62;  8'h21: lc = 8'h63;
         8'h23: lc = 8'h64;  8'h24: lc = 8'h65;  8'h2B: lc = 8'h66;
         8'h34: lc = 8'h67;  8'h33: lc = 8'h68;  8'h43: lc = 8'h69;
         8'h3B: lc = 8'h6A;  8'h42: lc = 8'h6B;  8'h4B: lc = 8'h6C;
         8'h3A: lc = 8'h6D;  8'h31: lc = 8'h6E;  8'h44: lc = 8'h6F;
         8'h4D: lc = 8'h70;  8'h15: lc = 8'h71;  8'h2D: lc = 8'h72;
         8'h1B: lc = 8'h73;  8'h2C: lc = 8'h74;  8'h3C: lc = 8'h75;
         8'h2A: lc = 8'h76;  8'h1D: lc = 8'h77;  8'h22: lc = 8'h78;
         8'h35: lc = 8'h79;  8'h1A: lc = 8'h7A;
         default: begin
            letter = 1'b0;
            case (c)
               8'h45: lc = 8'h30;  8'h16: lc = 8'h31;  8'h1E: lc = 8'h32;
               8'h26: lc = 8'h33;  8'h25: lc = 8'h34;  8'h2E: lc = 8'h35;
               8'h36: lc = 8'h36;  8'h3D: lc = 8'h37;  8'h3E: lc = 8'h38;
               8'h46: lc = 8'h39;  8'h29: lc = 8'h20;  8'h5A: lc = 8'h0D;
               default: lc = 8'h00;
            endcase
         end
      endcase
      return (letter && sh) ? (lc - 8'h20) : lc;
   endfunction

   always_comb begin
      state_d = state_q;
      shl_d   = shl_q;
      shr_d   = shr_q;
      code_d  = code_q;
      ascii_d = ascii_q;
      down_d  = down_q;
      valid_d = 1'b0;
      count_d = count_q;
      if (ready) begin
         case (state_q)
            IDLE: begin
               if (data == BYTE_BRK)      state_d = BRK;
               else if (data == BYTE_EXT) state_d = EXT;
               else if (data == LSHIFT)   shl_d = 1'b1;
               else if (data == RSHIFT)   shr_d = 1'b1;
               else if (!(down_q && data == code_q)) begin
                  code_d  = data;
                  ascii_d = ascii_map(data, shl_q | shr_q);
                  down_d  = 1'b1;
                  count_d = count_q + 8'd1;
                  valid_d = 1'b1;
               end
            end
            BRK: begin
               if (data == BYTE_EXT) state_d = EXT;
               else if (data != BYTE_BRK) begin
                  state_d = IDLE;
                  if (data == LSHIFT)      shl_d = 1'b0;
                  else if (data == RSHIFT) shr_d = 1'b0;
                  else if (data == code_q) down_d = 1'b0;
               end
            end
            EXT: begin
               if (data == BYTE_BRK)      state_d = EXT_BRK;
               else if (data != BYTE_EXT) state_d = IDLE;
            end
            EXT_BRK: begin
               if (data == BYTE_EXT)      state_d = EXT;
               else if (data != BYTE_BRK) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         shl_q   <= 1'b0;
         shr_q   <= 1'b0;
         code_q  <= 8'h00;
         ascii_q <= 8'h00;
         down_q  <= 1'b0;
         valid_q <= 1'b0;
         count_q <= 8'h00;
      end else begin
         state_q <= state_d;
         shl_q   <= shl_d;
         shr_q   <= shr_d;
         code_q  <= code_d;
         ascii_q <= ascii_d;
         down_q  <= down_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign scancode    = code_q;
   assign ascii       = ascii_q;
   assign key_down    = down_q;
   assign shift       = shl_q | shr_q;
   assign key_valid   = valid_q;
   assign press_count = count_q;

endmodule
